// File: rtl/en_bank_arbiter.sv
// Round-robin write arbiter for the enable-gated output register bank.
// One combinational grant per cycle, registered one-hot EN plus muxed data, and an idle SLEEP hint.
module en_bank_arbiter #(
    parameter int unsigned N           = 5,
    parameter int unsigned W           = 5,
    parameter int unsigned IDLE_CYCLES = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [N-1:0]   REQ,
    input  logic [N*W-1:0] REQ_DATA,
    output logic [N-1:0]   GNT,
    output logic [N-1:0]   EN,
    output logic [W-1:0]   D_OUT,
    output logic           SLEEP,
    output logic           BUSY
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(IDLE_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_SLEEP  = 2'd2;
    localparam logic [1:0] ST_WAKE   = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] idle_cnt_next;
    logic [PW-1:0] win;
    logic [PW-1:0] cand;
    logic          found;
    logic          grant;
    int unsigned   idx;

    // Rotating priority search starting at ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx  = (int'(ptr) + k) % N;
            cand = PW'(idx);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state, pointer, idle counter and combinational grant.
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        idle_cnt_next = idle_cnt;
        grant         = 1'b0;
        GNT           = '0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    grant         = 1'b1;
                    state_next    = ST_ACTIVE;
                    idle_cnt_next = '0;
                end else begin
                    if (idle_cnt < CW'(IDLE_CYCLES))
                        idle_cnt_next = idle_cnt + CW'(1);
                    if (idle_cnt >= CW'(IDLE_CYCLES - 1))
                        state_next = ST_SLEEP;
                end
            end
            ST_ACTIVE: begin
                idle_cnt_next = '0;
                if (found)
                    grant = 1'b1;
                else
                    state_next = ST_IDLE;
            end
            ST_SLEEP: begin
                if (REQ != '0)
                    state_next = ST_WAKE;
            end
            default: begin
                idle_cnt_next = '0;
                state_next    = ST_IDLE;
            end
        endcase
        if (!RST_N)
            grant = 1'b0;
        if (grant) begin
            GNT      = N'(1) << win;
            ptr_next = (win == PW'(N - 1)) ? '0 : win + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            idle_cnt <= '0;
            EN       <= '0;
            D_OUT    <= '0;
            SLEEP    <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            idle_cnt <= idle_cnt_next;
            EN       <= GNT;
            if (grant)
                D_OUT <= REQ_DATA[win*W +: W];
            SLEEP    <= (state_next == ST_SLEEP);
            BUSY     <= (state_next == ST_ACTIVE);
        end
    end

endmodule

// File: tb/tb_en_bank_arbiter.sv
// Directed scoreboard bench for en_bank_arbiter: grants checked in-cycle,
// expected EN/D_OUT queued and compared one cycle later.
module tb_en_bank_arbiter;

    localparam int unsigned N = 5;
    localparam int unsigned W = 5;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   en;
    logic [W-1:0]   d_out;
    logic           sleep;
    logic           busy;

    logic [W-1:0]       data_tab [N];
    logic [N+W-1:0]     exp_q [$];
    logic [W-1:0]       exp_dout;
    int                 n_checks;
    int                 n_pass;

    en_bank_arbiter #(.N(N), .W(W), .IDLE_CYCLES(4)) dut (
        .CLK(clk), .RST_N(rst_n), .REQ(req), .REQ_DATA(req_data),
        .GNT(gnt), .EN(en), .D_OUT(d_out), .SLEEP(sleep), .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    // Drive one cycle, check GNT in-cycle, queue and then check registered outputs.
    task automatic step(input string tag, input logic rst, input logic [N-1:0] r,
                        input logic [N-1:0] exp_gnt);
        logic [N+W-1:0] e;
        @(negedge clk);
        rst_n = rst;
        req   = r;
        #1;
        check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        if (!rst) exp_dout = '0;
        else begin
            for (int i = 0; i < N; i++)
                if (exp_gnt[i]) exp_dout = data_tab[i];
        end
        exp_q.push_back({(rst ? exp_gnt : N'(0)), exp_dout});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".en"}, 32'(en), 32'(e[N+W-1:W]));
        check({tag, ".dout"}, 32'(d_out), 32'(e[W-1:0]));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_dout = '0;
        data_tab[0] = 5'h11;
        data_tab[1] = 5'h0A;
        data_tab[2] = 5'h15;
        data_tab[3] = 5'h03;
        data_tab[4] = 5'h1E;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = data_tab[i];
        rst_n = 1'b0;
        req   = '1;

        // Reset held with all requests asserted.
        step("rst0", 1'b0, 5'b11111, 5'b00000);
        check("rst0.sleep", 32'(sleep), 32'd0);
        step("rst1", 1'b0, 5'b11111, 5'b00000);
        check("rst1.sleep", 32'(sleep), 32'd0);
        check("rst1.busy", 32'(busy), 32'd0);

        // Single request.
        step("single", 1'b1, 5'b00100, 5'b00100);
        check("single.busy", 32'(busy), 32'd1);
        step("single_off", 1'b1, 5'b00000, 5'b00000);
        check("single_off.busy", 32'(busy), 32'd0);

        // Move pointer to 0, then full round-robin.
        step("to_ptr0", 1'b1, 5'b10000, 5'b10000);
        check("to_ptr0.ptr", 32'(dut.ptr), 32'd0);
        step("rr0", 1'b1, 5'b11111, 5'b00001);
        step("rr1", 1'b1, 5'b11111, 5'b00010);
        step("rr2", 1'b1, 5'b11111, 5'b00100);
        step("rr3", 1'b1, 5'b11111, 5'b01000);
        step("rr4", 1'b1, 5'b11111, 5'b10000);
        step("rr5", 1'b1, 5'b11111, 5'b00001);
        step("rr_off", 1'b1, 5'b00000, 5'b00000);

        // Wrap and skip from ptr=4.
        step("to_ptr4", 1'b1, 5'b01000, 5'b01000);
        check("to_ptr4.ptr", 32'(dut.ptr), 32'd4);
        step("wrap0", 1'b1, 5'b01010, 5'b00010);
        check("wrap0.ptr", 32'(dut.ptr), 32'd2);
        step("wrap1", 1'b1, 5'b01010, 5'b01000);
        check("wrap1.ptr", 32'(dut.ptr), 32'd4);
        step("wrap2", 1'b1, 5'b01010, 5'b00010);
        check("wrap2.ptr", 32'(dut.ptr), 32'd2);
        step("wrap_off", 1'b1, 5'b00000, 5'b00000);

        // Idle into sleep, then wake.
        step("idle1", 1'b1, 5'b00000, 5'b00000);
        step("idle2", 1'b1, 5'b00000, 5'b00000);
        step("idle3", 1'b1, 5'b00000, 5'b00000);
        check("idle3.sleep", 32'(sleep), 32'd0);
        step("idle4", 1'b1, 5'b00000, 5'b00000);
        check("idle4.sleep", 32'(sleep), 32'd1);
        step("sleep_req", 1'b1, 5'b00001, 5'b00000);
        check("sleep_req.sleep", 32'(sleep), 32'd0);
        step("wake", 1'b1, 5'b00001, 5'b00000);
        check("wake.sleep", 32'(sleep), 32'd0);
        step("wake_gnt", 1'b1, 5'b00001, 5'b00001);
        check("wake_gnt.busy", 32'(busy), 32'd1);

        // Reset mid-burst.
        step("burst", 1'b1, 5'b11111, 5'b00010);
        step("mid_rst", 1'b0, 5'b11111, 5'b00000);
        check("mid_rst.ptr", 32'(dut.ptr), 32'd0);
        check("mid_rst.busy", 32'(busy), 32'd0);
        step("post_rst", 1'b1, 5'b11111, 5'b00001);
        step("post_rst1", 1'b1, 5'b11111, 5'b00010);
        step("end_off", 1'b1, 5'b00000, 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
